// File: rtl/ahb_arb_pkg.sv
// AHB arbiter shared types: HTRANS/HBURST/HRESP encodings, FSM states, burst length.
// No latency (types and a pure function only).
// No flow control involved.
`include "ahb_type.svh"

package ahb_arb_pkg;

  localparam int HTRANS_W = `AHB_TYPE_WIDTH;
  localparam int HBURST_W = `AHB_BURST_WIDTH;
  localparam int HRESP_W  = `AHB_RESP_WIDTH;
  localparam int BEAT_W   = 5;

  typedef enum logic [HTRANS_W-1:0] {
    TRN_IDLE   = 2'd0,
    TRN_BUSY   = 2'd1,
    TRN_NONSEQ = 2'd2,
    TRN_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [HBURST_W-1:0] {
    BST_SINGLE = 3'd0,
    BST_INCR   = 3'd1,
    BST_WRAP4  = 3'd2,
    BST_INCR4  = 3'd3,
    BST_WRAP8  = 3'd4,
    BST_INCR8  = 3'd5,
    BST_WRAP16 = 3'd6,
    BST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [HRESP_W-1:0] {
    RSP_OKAY  = 2'd0,
    RSP_ERROR = 2'd1,
    RSP_RETRY = 2'd2,
    RSP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2,
    ST_LOCKED = 2'd3
  } arb_state_e;

  // Beats in a fixed-length burst; 0 means undefined length (SINGLE/INCR).
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [HBURST_W-1:0] hburst);
    logic [BEAT_W-1:0] beats;
    case (hburst)
      BST_WRAP4,  BST_INCR4:  beats = 5'd4;
      BST_WRAP8,  BST_INCR8:  beats = 5'd8;
      BST_WRAP16, BST_INCR16: beats = 5'd16;
      default:                beats = 5'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Round-robin request picker: search starts one past the last granted index.
// Purely combinational, zero latency.
// No flow control; vld=0 when no request is pending.
module ahb_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          vld
);

  logic [IW-1:0] idx;

  // Walk the requests from ptr+1 around to ptr, take the first one found.
  always_comb begin
    pick = '0;
    vld  = 1'b0;
    idx  = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!vld && req[idx]) begin
        pick[idx] = 1'b1;
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_type.svh
// AHB field widths shared by the arbiter package and anything that talks AHB.
// Pure defines, no logic; guarded so multiple includes are harmless.
// Change here only if the bus definition itself changes.
`ifndef AHB_TYPE_SVH
`define AHB_TYPE_SVH
`define AHB_TYPE_WIDTH  2
`define AHB_BURST_WIDTH 3
`define AHB_RESP_WIDTH  2
`endif

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with single/burst/locked ownership tracking.
// Grant registered 1 cycle after an arbitration point; hmaster follows on next hready.
// hready=0 freezes hmaster/hmastlock and all ownership decisions except reset.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int DEF_MST = 0
) (
  input  logic                       clk,
  input  logic                       hreset,
  input  logic [NUM_MST-1:0]         hbusreq,
  input  logic [NUM_MST-1:0]         hlock,
  input  logic [HTRANS_W-1:0]        htrans,
  input  logic [HBURST_W-1:0]        hburst,
  input  logic                       hready,
  input  logic [HRESP_W-1:0]         hresp,
  output logic [NUM_MST-1:0]         hgrant,
  output logic [$clog2(NUM_MST)-1:0] hmaster,
  output logic                       hmastlock
);

  localparam int                 MW      = $clog2(NUM_MST);
  localparam logic [MW-1:0]      DEF_IDX = MW'(DEF_MST);
  localparam logic [NUM_MST-1:0] DEF_GNT = NUM_MST'(1) << DEF_MST;

  arb_state_e        state;
  logic [MW-1:0]     gnt_idx;
  logic [MW-1:0]     ptr;
  logic [BEAT_W-1:0] cnt;
  logic              lk_rel;

  logic [NUM_MST-1:0] pick;
  logic               pick_vld;
  logic [MW-1:0]      pick_idx;
  logic               own;
  logic               err_pt;
  logic               arb_pt;

  ahb_arb_rr_pick #(.N(NUM_MST), .IW(MW)) u_pick (
    .req  (hbusreq),
    .ptr  (ptr),
    .pick (pick),
    .vld  (pick_vld)
  );

  // Encode the one-hot pick into the index that hmaster will later carry.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (pick[i]) pick_idx = MW'(i);
    end
  end

  // Arbitration point detection; htrans only counts once the granted master
  // actually owns the address phase, otherwise it belongs to the old owner.
  always_comb begin
    own    = (hmaster == gnt_idx);
    err_pt = hready && (hresp != RSP_OKAY);
    arb_pt = 1'b0;
    if (hready) begin
      if (err_pt || state == ST_IDLE) begin
        arb_pt = 1'b1;
      end else if (own) begin
        case (state)
          ST_SINGLE: arb_pt = (htrans == TRN_IDLE) || !hbusreq[gnt_idx];
          ST_BURST:  arb_pt = (htrans == TRN_IDLE) ||
                              ((htrans == TRN_SEQ) && (cnt == 5'd1));
          ST_LOCKED: arb_pt = lk_rel;
          default:   arb_pt = 1'b0;
        endcase
      end
    end
  end

  // Ownership FSM with registered grant, address-phase master and lock flag.
  always_ff @(posedge clk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      hgrant    <= DEF_GNT;
      gnt_idx   <= DEF_IDX;
      ptr       <= DEF_IDX;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
      cnt       <= '0;
      lk_rel    <= 1'b0;
    end else begin
      if (hready) begin
        hmaster   <= gnt_idx;
        hmastlock <= hlock[gnt_idx];
      end
      if (arb_pt) begin
        cnt    <= '0;
        lk_rel <= 1'b0;
        if (pick_vld) begin
          hgrant  <= pick;
          gnt_idx <= pick_idx;
          ptr     <= pick_idx;
          state   <= hlock[pick_idx] ? ST_LOCKED : ST_SINGLE;
        end else begin
          hgrant  <= DEF_GNT;
          gnt_idx <= DEF_IDX;
          state   <= ST_IDLE;
        end
      end else if (hready && own) begin
        case (state)
          ST_SINGLE, ST_BURST: begin
            if (htrans == TRN_NONSEQ) begin
              if (burst_beats(hburst) != 5'd0) begin
                cnt   <= burst_beats(hburst) - 5'd1;
                state <= ST_BURST;
              end else begin
                cnt   <= '0;
                state <= ST_SINGLE;
              end
            end else if (htrans == TRN_SEQ && state == ST_BURST) begin
              cnt <= cnt - 5'd1;
            end
          end
          // Lock dropped: the owner keeps the bus for exactly one more transfer.
          ST_LOCKED: if (!hlock[gnt_idx]) lk_rel <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: each stimulus cycle queues the outputs
// expected after the next clock edge; a negedge monitor pops and compares.
module tb_ahb_arbiter;
  import ahb_arb_pkg::*;

  logic       clk;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int         qt[$];
  logic [3:0] qg[$];
  logic [1:0] qm[$];
  logic       ql[$];
  string      qn[$];

  ahb_arbiter #(.NUM_MST(4), .DEF_MST(0)) dut (
    .clk       (clk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant must be one-hot every cycle; queued expectations are
  // compared in the cycle they target.
  always @(negedge clk) begin
    int         t;
    logic [3:0] eg;
    logic [1:0] em;
    logic       el;
    string      nm;
    if (cyc >= 1) begin
      n_vec++;
      if (!$onehot(hgrant)) begin
        n_err++;
        $display("FAIL onehot @cyc %0d: hgrant=%b is not one-hot", cyc, hgrant);
      end
    end
    while (qt.size() > 0 && qt[0] <= cyc) begin
      t  = qt.pop_front();
      eg = qg.pop_front();
      em = qm.pop_front();
      el = ql.pop_front();
      nm = qn.pop_front();
      n_vec++;
      if (t != cyc || hgrant !== eg || hmaster !== em || hmastlock !== el) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got hgrant=%b hmaster=%0d hmastlock=%b, want hgrant=%b hmaster=%0d hmastlock=%b",
                 nm, cyc, hgrant, hmaster, hmastlock, eg, em, el);
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [1:0] rsp, input logic [3:0] eg, input logic [1:0] em,
                       input logic el, input string nm);
    hreset  = rst;
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rsp;
    qt.push_back(cyc + 1);
    qg.push_back(eg);
    qm.push_back(em);
    ql.push_back(el);
    qn.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                     input logic rdy, input logic [3:0] eg, input logic [1:0] em,
                     input string nm);
    drive(1'b0, req, 4'b0000, tr, bu, rdy, RSP_OKAY, eg, em, 1'b0, nm);
  endtask

  initial begin
    hreset  = 1'b1;
    hbusreq = '0;
    hlock   = '0;
    htrans  = TRN_IDLE;
    hburst  = BST_SINGLE;
    hready  = 1'b1;
    hresp   = RSP_OKAY;
    @(posedge clk);
    #1;

    // Reset state and idle hold with the default master parked.
    drive(1'b1, 4'b0000, 4'b0000, TRN_IDLE, BST_SINGLE, 1'b1, RSP_OKAY, 4'b0001, 2'd0, 1'b0, "rst_state");
    for (int i = 0; i < 10; i++) bus(4'b0000, TRN_IDLE, BST_SINGLE, 1'b1, 4'b0001, 2'd0, "idle_hold");

    // M1/M2 request on a free bus, M1 runs INCR4.
    bus(4'b0110, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b0010, 2'd0, "free_grant_m1");
    bus(4'b0110, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b0010, 2'd1, "handover_m1");
    bus(4'b0110, TRN_NONSEQ, BST_INCR4,  1'b1, 4'b0010, 2'd1, "incr4_b1");
    bus(4'b0110, TRN_SEQ,    BST_INCR4,  1'b1, 4'b0010, 2'd1, "incr4_b2");
    bus(4'b0110, TRN_SEQ,    BST_INCR4,  1'b1, 4'b0010, 2'd1, "incr4_b3");
    bus(4'b0110, TRN_SEQ,    BST_INCR4,  1'b1, 4'b0100, 2'd1, "incr4_last");

    // M2 INCR8 with wait states at beats 3 and 6; M2 drops its request mid burst.
    bus(4'b1100, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b0100, 2'd2, "handover_m2");
    bus(4'b1100, TRN_NONSEQ, BST_INCR8,  1'b1, 4'b0100, 2'd2, "incr8_b1");
    bus(4'b1100, TRN_SEQ,    BST_INCR8,  1'b1, 4'b0100, 2'd2, "incr8_b2");
    bus(4'b1100, TRN_SEQ,    BST_INCR8,  1'b0, 4'b0100, 2'd2, "incr8_wait3");
    bus(4'b1000, TRN_SEQ,    BST_INCR8,  1'b1, 4'b0100, 2'd2, "incr8_b3");
    bus(4'b1000, TRN_SEQ,    BST_INCR8,  1'b1, 4'b0100, 2'd2, "incr8_b4");
    bus(4'b1000, TRN_SEQ,    BST_INCR8,  1'b1, 4'b0100, 2'd2, "incr8_b5");
    bus(4'b1000, TRN_SEQ,    BST_INCR8,  1'b0, 4'b0100, 2'd2, "incr8_wait6");
    bus(4'b1000, TRN_SEQ,    BST_INCR8,  1'b1, 4'b0100, 2'd2, "incr8_b6");
    bus(4'b1000, TRN_SEQ,    BST_INCR8,  1'b1, 4'b0100, 2'd2, "incr8_b7");
    bus(4'b1000, TRN_SEQ,    BST_INCR8,  1'b1, 4'b1000, 2'd2, "incr8_last");

    // M3 INCR16 interrupted by reset; pointer must restart from the default.
    bus(4'b1000, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b1000, 2'd3, "handover_m3");
    bus(4'b1000, TRN_NONSEQ, BST_INCR16, 1'b1, 4'b1000, 2'd3, "incr16_b1");
    bus(4'b1000, TRN_SEQ,    BST_INCR16, 1'b1, 4'b1000, 2'd3, "incr16_b2");
    bus(4'b1000, TRN_SEQ,    BST_INCR16, 1'b1, 4'b1000, 2'd3, "incr16_b3");
    drive(1'b1, 4'b1000, 4'b0000, TRN_SEQ, BST_INCR16, 1'b1, RSP_OKAY, 4'b0001, 2'd0, 1'b0, "rst_mid_burst");
    bus(4'b0000, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b0001, 2'd0, "post_rst_idle");
    bus(4'b1001, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b1000, 2'd0, "ptr_after_rst");
    bus(4'b0000, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b1000, 2'd3, "handover_m3b");
    bus(4'b0000, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b0001, 2'd3, "release_idle");
    bus(4'b0000, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b0001, 2'd0, "back_to_def");

    // M1 locked for 12 transfers against full contention, then round-robin.
    drive(1'b1, 4'b0000, 4'b0000, TRN_IDLE, BST_SINGLE, 1'b1, RSP_OKAY, 4'b0001, 2'd0, 1'b0, "rst2");
    drive(1'b0, 4'b1111, 4'b0010, TRN_IDLE, BST_SINGLE, 1'b1, RSP_OKAY, 4'b0010, 2'd0, 1'b0, "lock_grant");
    drive(1'b0, 4'b1111, 4'b0010, TRN_IDLE, BST_SINGLE, 1'b1, RSP_OKAY, 4'b0010, 2'd1, 1'b1, "lock_handover");
    for (int i = 0; i < 12; i++)
      drive(1'b0, 4'b1111, 4'b0010, TRN_NONSEQ, BST_SINGLE, 1'b1, RSP_OKAY, 4'b0010, 2'd1, 1'b1, "lock_hold");
    drive(1'b0, 4'b1111, 4'b0000, TRN_NONSEQ, BST_SINGLE, 1'b1, RSP_OKAY, 4'b0010, 2'd1, 1'b0, "lock_drop");
    drive(1'b0, 4'b1111, 4'b0000, TRN_NONSEQ, BST_SINGLE, 1'b1, RSP_OKAY, 4'b0100, 2'd1, 1'b0, "lock_release");
    bus(4'b1111, TRN_IDLE, BST_SINGLE, 1'b1, 4'b0100, 2'd2, "rr_handover_m2");
    bus(4'b1111, TRN_IDLE, BST_SINGLE, 1'b1, 4'b1000, 2'd2, "rr_m3");
    bus(4'b1111, TRN_IDLE, BST_SINGLE, 1'b1, 4'b1000, 2'd3, "rr_handover_m3");
    bus(4'b1111, TRN_IDLE, BST_SINGLE, 1'b1, 4'b0001, 2'd3, "rr_m0");
    bus(4'b1111, TRN_IDLE, BST_SINGLE, 1'b1, 4'b0001, 2'd0, "rr_handover_m0");
    bus(4'b1111, TRN_IDLE, BST_SINGLE, 1'b1, 4'b0010, 2'd0, "rr_m1");

    // M0 WRAP16 aborted by a two-cycle RETRY at beat 5; M2 takes over.
    drive(1'b1, 4'b0000, 4'b0000, TRN_IDLE, BST_SINGLE, 1'b1, RSP_OKAY, 4'b0001, 2'd0, 1'b0, "rst3");
    bus(4'b0001, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b0001, 2'd0, "m0_grant");
    bus(4'b0101, TRN_NONSEQ, BST_WRAP16, 1'b1, 4'b0001, 2'd0, "wrap16_b1");
    for (int i = 0; i < 4; i++) bus(4'b0101, TRN_SEQ, BST_WRAP16, 1'b1, 4'b0001, 2'd0, "wrap16_seq");
    drive(1'b0, 4'b0101, 4'b0000, TRN_IDLE, BST_WRAP16, 1'b0, RSP_RETRY, 4'b0001, 2'd0, 1'b0, "retry_c1");
    drive(1'b0, 4'b0101, 4'b0000, TRN_IDLE, BST_WRAP16, 1'b1, RSP_RETRY, 4'b0100, 2'd0, 1'b0, "retry_c2");
    bus(4'b0101, TRN_IDLE,   BST_SINGLE, 1'b1, 4'b0100, 2'd2, "retry_handover");
    bus(4'b0101, TRN_NONSEQ, BST_SINGLE, 1'b1, 4'b0100, 2'd2, "m2_single");
    bus(4'b0001, TRN_NONSEQ, BST_SINGLE, 1'b1, 4'b0001, 2'd2, "m2_drop_req");

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MST, default 4, number of AHB masters sharing the bus (2..8).
REQ-002 Parameter DEF_MST, default 0, default master granted when no request is pending.
REQ-003 clk  input  1  bus clock; all state updates on posedge clk.
REQ-004 hreset  input  1  one clock; reset is synchronous and active-high.
REQ-005 hbusreq  input  NUM_MST  per-master bus request.
REQ-006 hlock  input  NUM_MST  per-master locked-access request.
REQ-007 htrans  input  AHB_TYPE_WIDTH (2)  transfer type of current bus owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 hburst  input  AHB_BURST_WIDTH (3)  burst type of current owner (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16).
REQ-009 hready  input  1  bus ready from selected slave.
REQ-010 hresp  input  2  slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
REQ-011 hgrant  output  NUM_MST  one-hot grant, registered.
REQ-012 hmaster  output  clog2(NUM_MST)  index of master owning the address phase, registered.
REQ-013 hmastlock  output  1  current address-phase transfer is locked, registered.

Function
REQ-014 hgrant SHALL be one-hot at all times, including reset.
REQ-015 States SHALL be: IDLE (default master granted, no owned burst), SINGLE (owner doing single or undefined-length transfers), BURST (fixed-length burst in progress), LOCKED (owner holding hlock).
REQ-016 Arbitration point: hready=1 and one of: state IDLE; htrans=IDLE; SINGLE state with owner hbusreq=0; BURST beat counter reaching last beat; ERROR/RETRY/SPLIT response second cycle.
REQ-017 At an arbitration point the next grant SHALL be chosen round-robin, starting at index (last granted master + 1) mod NUM_MST; no request selects DEF_MST and enters IDLE.
REQ-018 New hgrant SHALL appear on the cycle after the arbitration point (1-cycle latency from request to grant on a free bus).
REQ-019 hmaster SHALL load the granted index on the first posedge with hready=1 and hgrant changed; hmaster SHALL never change while hready=0.
REQ-020 NONSEQ with hready=1 and hburst in {INCR4,WRAP4,INCR8,WRAP8,INCR16,WRAP16} SHALL load a 5-bit beat counter with 4/8/16 minus 1 and enter BURST; each SEQ with hready=1 decrements; BUSY holds the counter.
REQ-021 hburst SINGLE or INCR SHALL enter SINGLE state; grant held while owner keeps hbusreq=1.
REQ-022 Owner hlock=1 at arbitration point SHALL enter LOCKED; grant held regardless of other requests until owner hlock=0 and one further transfer completes with hready=1.
REQ-023 hmastlock SHALL equal the owner hlock registered with hmaster update, i.e. aligned to the address phase.
REQ-024 ERROR, RETRY or SPLIT (hready=0 then hready=1 second cycle) SHALL abort the beat counter and force an arbitration point; SPLIT SHALL be treated as RETRY (no split masking).
REQ-025 Simultaneous requests SHALL resolve purely by round-robin pointer; a continuously requesting master SHALL be granted within NUM_MST arbitration points.
REQ-026 Request from the current owner deasserted mid fixed burst SHALL NOT shorten the burst.

Reset
REQ-027 hreset=1 at posedge SHALL set hgrant=one-hot(DEF_MST), hmaster=DEF_MST, hmastlock=0, pointer=DEF_MST, beat counter=0, state IDLE, overriding any burst or lock in progress.
REQ-028 First arbitration SHALL occur at the first posedge after hreset deasserts.

Structure
REQ-029 Package ahb_arb_pkg SHALL hold HTRANS, HBURST, HRESP encodings, state enum and burst-length function; widths come from ahb_type.svh.
REQ-030 Combinational sub-module ahb_arb_rr_pick (requests, pointer -> one-hot pick, valid) SHALL implement REQ-017.

Verification
REQ-031 Reset, no requests -> hgrant=0001, hmaster=0, hmastlock=0, held for 10 cycles.
REQ-032 hbusreq=0110 on free bus, pointer=0 -> hgrant=0010 next cycle; after INCR4 from M1 (4 beats, hready=1) -> hgrant=0100 cycle after 4th beat.
REQ-033 M2 INCR8 with hready=0 inserted at beats 3 and 6, M3 requesting -> hmaster stays 2 for all 8 beats, hgrant=1000 only after beat 8.
REQ-034 M1 hlock=1 with hbusreq=1111 for 12 transfers -> hgrant=0010, hmastlock=1 throughout; released one transfer after hlock drops.
REQ-035 M0 WRAP16, RETRY at beat 5 -> counter aborted, next requester granted after second response cycle.
REQ-036 hreset asserted mid M3 INCR16 -> next cycle hgrant=0001, hmaster=0, state IDLE.
